// File: rtl/alu_result_buffer_if.sv
`default_nettype none
// ============================================================================
// alu_result_buffer_if : handshake bundle between ALU, result buffer, writeback
// Revision 1.0 - initial release
// ============================================================================
interface alu_result_buffer_if #(
    parameter int WORD_SIZE  = 19,
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_SIZE-1:0]  in_result;
    logic [REG_ADDR_W-1:0] in_dest;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_SIZE-1:0]  out_result;
    logic [REG_ADDR_W-1:0] out_dest;
    logic [2:0]            out_flags;
    logic [CW-1:0]         occupancy;

    modport master (
        output flush, in_valid, in_result, in_dest, out_ready,
        input  in_ready, out_valid, out_result, out_dest, out_flags, occupancy
    );

    modport slave (
        input  flush, in_valid, in_result, in_dest, out_ready,
        output in_ready, out_valid, out_result, out_dest, out_flags, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/alu_result_buffer.sv
`default_nettype none
// ============================================================================
// alu_result_buffer : FIFO of ALU results with {P,N,Z} flags; optional
// parity flag built when ALU_RESULT_PARITY_EN is defined.  Revision 1.0
// ============================================================================
module alu_result_buffer #(
    parameter int WORD_SIZE  = 19,
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 2
) (
    input  logic              clk,
    input  logic              rst,
    alu_result_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    logic [WORD_SIZE-1:0]  r_result [DEPTH];
    logic [REG_ADDR_W-1:0] r_dest   [DEPTH];
    logic [1:0]            r_nz     [DEPTH];
`ifdef ALU_RESULT_PARITY_EN
    logic                  r_par    [DEPTH];
`endif

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    // Ready depends only on registered occupancy, so no path from out_ready.
    assign w_in_ready  = (r_count != C_FULL);
    assign w_out_valid = (r_count != '0);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_result[i] <= '0;
                r_dest[i]   <= '0;
                r_nz[i]     <= '0;
`ifdef ALU_RESULT_PARITY_EN
                r_par[i]    <= 1'b0;
`endif
            end
        end else if (w_push && !bus.flush) begin
            r_result[r_wr_ptr] <= bus.in_result;
            r_dest[r_wr_ptr]   <= bus.in_dest;
            r_nz[r_wr_ptr]     <= {bus.in_result[WORD_SIZE-1], (bus.in_result == '0)};
`ifdef ALU_RESULT_PARITY_EN
            r_par[r_wr_ptr]    <= ^bus.in_result;
`endif
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_result = r_result[r_rd_ptr];
    assign bus.out_dest   = r_dest[r_rd_ptr];
    assign bus.occupancy  = r_count;
`ifdef ALU_RESULT_PARITY_EN
    assign bus.out_flags  = {r_par[r_rd_ptr], r_nz[r_rd_ptr]};
`else
    assign bus.out_flags  = {1'b0, r_nz[r_rd_ptr]};
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_buffer.sv
`default_nettype none
// ============================================================================
// tb_alu_result_buffer : directed self-checking bench for alu_result_buffer
// Revision 1.0 - initial release
// ============================================================================
module tb_alu_result_buffer;
    localparam int WORD_SIZE  = 19;
    localparam int REG_ADDR_W = 4;
    localparam int DEPTH      = 2;
`ifdef ALU_RESULT_PARITY_EN
    localparam logic c_par = 1'b1;
`else
    localparam logic c_par = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    alu_result_buffer_if #(
        .WORD_SIZE (WORD_SIZE),
        .REG_ADDR_W(REG_ADDR_W),
        .DEPTH     (DEPTH)
    ) bus ();

    alu_result_buffer #(
        .WORD_SIZE (WORD_SIZE),
        .REG_ADDR_W(REG_ADDR_W),
        .DEPTH     (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.in_dest   = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        check_eq("rst_occ",    32'(bus.occupancy),  0);
        check_eq("rst_ovalid", 32'(bus.out_valid),  0);
        check_eq("rst_iready", 32'(bus.in_ready),   1);
        check_eq("rst_result", 32'(bus.out_result), 0);
        check_eq("rst_dest",   32'(bus.out_dest),   0);
        check_eq("rst_flags",  32'(bus.out_flags),  0);
        rst = 1'b0;
        step();

        // Single zero result, immediately consumed
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_result = 19'h00000;
        bus.in_dest   = 4'd3;
        step();
        bus.in_valid  = 1'b0;
        check_eq("t1_valid",  32'(bus.out_valid),  1);
        check_eq("t1_result", 32'(bus.out_result), 0);
        check_eq("t1_dest",   32'(bus.out_dest),   3);
        check_eq("t1_flags",  32'(bus.out_flags),  32'b001);
        step();
        check_eq("t1_empty",  32'(bus.out_valid),  0);

        // Fill to full under backpressure, then drain in order
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_result = 19'h40000;
        bus.in_dest   = 4'd1;
        step();
        check_eq("t2_ready_mid", 32'(bus.in_ready), 1);
        bus.in_result = 19'h00007;
        bus.in_dest   = 4'd2;
        step();
        bus.in_valid  = 1'b0;
        check_eq("t2_ready_full", 32'(bus.in_ready),   0);
        check_eq("t2_occ_full",   32'(bus.occupancy),  2);
        check_eq("t2_head0",      32'(bus.out_result), 32'h40000);
        check_eq("t2_flags0",     32'(bus.out_flags),  32'({c_par, 2'b10}));
        check_eq("t2_dest0",      32'(bus.out_dest),   1);
        bus.out_ready = 1'b1;
        step();
        check_eq("t2_head1",      32'(bus.out_result), 32'h00007);
        check_eq("t2_flags1",     32'(bus.out_flags),  32'({c_par, 2'b00}));
        check_eq("t2_dest1",      32'(bus.out_dest),   2);
        check_eq("t2_ready_back", 32'(bus.in_ready),   1);
        step();
        check_eq("t2_drained",    32'(bus.out_valid),  0);

        // Streaming at one entry per cycle
        for (int i = 0; i < 20; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_result = 19'(100 + i);
            bus.in_dest   = 4'(i);
            step();
            check_eq("t3_valid",  32'(bus.out_valid),  1);
            check_eq("t3_result", 32'(bus.out_result), 32'(100 + i));
            check_eq("t3_dest",   32'(bus.out_dest),   32'(i % 16));
            check_eq("t3_occ",    32'(bus.occupancy),  1);
        end
        bus.in_valid = 1'b0;
        step();
        check_eq("t3_empty", 32'(bus.out_valid), 0);

        // Flush with a concurrent push while two entries are held
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_result = 19'h0AAAA;
        step();
        bus.in_result = 19'h05555;
        step();
        check_eq("t4_occ_pre", 32'(bus.occupancy), 2);
        bus.flush     = 1'b1;
        bus.in_result = 19'h0CCCC;
        step();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        check_eq("t4_occ",    32'(bus.occupancy), 0);
        check_eq("t4_valid",  32'(bus.out_valid), 0);
        check_eq("t4_iready", 32'(bus.in_ready),  1);
        bus.out_ready = 1'b1;
        step();
        check_eq("t4_stays_empty", 32'(bus.out_valid), 0);
        bus.in_valid  = 1'b1;
        bus.in_result = 19'h01234;
        bus.in_dest   = 4'd7;
        step();
        bus.in_valid  = 1'b0;
        check_eq("t4_fresh_result", 32'(bus.out_result), 32'h01234);
        check_eq("t4_fresh_dest",   32'(bus.out_dest),   7);
        step();

        // Asynchronous reset between edges with one entry held
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_result = 19'h12345;
        bus.in_dest   = 4'd5;
        step();
        bus.in_valid  = 1'b0;
        check_eq("t5_occ_pre",    32'(bus.occupancy),  1);
        check_eq("t5_result_pre", 32'(bus.out_result), 32'h12345);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t5_async_valid",  32'(bus.out_valid),  0);
        check_eq("t5_async_result", 32'(bus.out_result), 0);
        check_eq("t5_async_occ",    32'(bus.occupancy),  0);
        step();
        rst = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_result = 19'h00001;
        bus.in_dest   = 4'd9;
        step();
        bus.in_valid  = 1'b0;
        check_eq("t5_fresh_occ",    32'(bus.occupancy),  1);
        check_eq("t5_fresh_result", 32'(bus.out_result), 1);
        check_eq("t5_fresh_dest",   32'(bus.out_dest),   9);
        check_eq("t5_parity_flags", 32'(bus.out_flags),  32'({c_par, 2'b00}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
